// File: rtl/muldiv_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitude and result sign correction.
module muldiv_sign_fix #(
  parameter int unsigned W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = neg ? -din : din;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: one bit per cycle over a shared shift/add-subtract datapath.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_p_q, neg_p_d;
  logic             neg_r_q, neg_r_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_abs, b_abs, rem_fix;
  logic [2*WIDTH-1:0] prod_in, prod_fix;
  logic [WIDTH:0]     sum, shifted, trial;

  // Signed ops work on magnitudes; signs are re-applied at FIX
  always_comb begin
    sign_a  = ~op[0] & a[WIDTH-1];
    sign_b  = ~op[0] & b[WIDTH-1];
    prod_in = is_div_q ? {{WIDTH{1'b0}}, acc_lo_q} : {acc_hi_q, acc_lo_q};
  end

  muldiv_sign_fix #(.W(WIDTH))   u_abs_a (.neg(sign_a),  .din(a),        .dout(a_abs));
  muldiv_sign_fix #(.W(WIDTH))   u_abs_b (.neg(sign_b),  .din(b),        .dout(b_abs));
  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_p (.neg(neg_p_q), .din(prod_in),  .dout(prod_fix));
  muldiv_sign_fix #(.W(WIDTH))   u_fix_r (.neg(neg_r_q), .din(acc_hi_q), .dout(rem_fix));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, mcand_q};

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          state_d  = S_CALC;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_p_d  = sign_a ^ sign_b;
          neg_r_d  = sign_a;
          div0_d   = op[1] && (b == '0);
          acc_hi_d = '0;
          mcand_d  = op[1] ? b_abs : a_abs;
          acc_lo_d = op[1] ? a_abs : b_abs;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_d) begin
          // A set borrow bit means the trial subtract went negative: restore
          if (!trial[WIDTH]) begin
            acc_hi_d = trial[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = shifted[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = sum[WIDTH:1];
          acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = div0_q;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : prod_fix[WIDTH-1:0];
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Cancel overrides everything, including a completing FIX
    if (cancel && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
